// File: rtl/piso_bit_feeder_pkg.sv
// Shared definitions for the serial feeder and the detector-side benches.
// State encodings plus the default word width and idle level.
package piso_bit_feeder_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;
  localparam int   DEFAULT_CNT_W    = 16;

  // Width of a down-counter that must hold values 0 .. w-1.
  function automatic int cnt_width(input int w);
    cnt_width = (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder for the Moore pattern detector's Din input.
// One-word hold buffer behind the shift register gives gapless streaming.
module piso_bit_feeder
  import piso_bit_feeder_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter bit   IDLE_BIT  = DEFAULT_IDLE_BIT,
  parameter int   CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [WIDTH-1:0] hold_reg, hold_n;
  logic             hold_full, hold_full_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] word_cnt_n;
  logic             dout_n, dout_valid_n, frame_start_n;
  logic             transfer;
  logic             load_word;
  logic [WIDTH-1:0] word_in;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    if (MSB_FIRST)
      shift_once = {s[WIDTH-2:0], 1'b0};
    else
      shift_once = {1'b0, s[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] s);
    if (MSB_FIRST)
      head_bit = s[WIDTH-1];
    else
      head_bit = s[0];
  endfunction

  assign load_ready = !hold_full;
  assign transfer   = load_valid && load_ready;
  assign busy       = (state == S_SHIFT) || hold_full;

  // A word reaches the shift register either straight from the input (bypass)
  // or from the hold buffer; dout is computed from the post-edge register so it
  // can be flopped alongside it.
  always_comb begin
    state_n       = state;
    shift_n       = shift_reg;
    hold_n        = hold_reg;
    hold_full_n   = hold_full;
    bit_cnt_n     = bit_cnt;
    word_cnt_n    = word_cnt;
    frame_start_n = 1'b0;
    load_word     = 1'b0;
    word_in       = load_data;

    case (state)
      S_IDLE: begin
        if (transfer) begin
          load_word = 1'b1;
          word_in   = load_data;
        end
      end
      S_SHIFT: begin
        if (bit_cnt != '0) begin
          shift_n   = shift_once(shift_reg);
          bit_cnt_n = bit_cnt - BW'(1);
          if (transfer) begin
            hold_n      = load_data;
            hold_full_n = 1'b1;
          end
        end else begin
          word_cnt_n = word_cnt + CNT_W'(1);
          if (hold_full) begin
            load_word   = 1'b1;
            word_in     = hold_reg;
            hold_full_n = 1'b0;
          end else if (transfer) begin
            load_word = 1'b1;
            word_in   = load_data;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (load_word) begin
      shift_n       = word_in;
      bit_cnt_n     = LAST_IDX;
      state_n       = S_SHIFT;
      frame_start_n = 1'b1;
    end

    dout_valid_n = (state_n == S_SHIFT);
    dout_n       = dout_valid_n ? head_bit(shift_n) : IDLE_BIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      shift_reg   <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      dout        <= IDLE_BIT;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      shift_reg   <= shift_n;
      hold_reg    <= hold_n;
      hold_full   <= hold_full_n;
      bit_cnt     <= bit_cnt_n;
      word_cnt    <= word_cnt_n;
      dout        <= dout_n;
      dout_valid  <= dout_valid_n;
      frame_start <= frame_start_n;
    end
  end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Scenario bench for piso_bit_feeder: an MSB-first instance and an
// LSB-first instance with a 2-bit word counter, checked against a bit queue.
module tb_piso_bit_feeder;

  typedef struct packed {
    logic b;
    logic first;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       m_lv = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_ready, m_dout, m_dvalid, m_frame, m_busy;
  logic [15:0] m_cnt;

  logic       l_lv = 1'b0;
  logic [7:0] l_data = '0;
  logic       l_ready, l_dout, l_dvalid, l_frame, l_busy;
  logic [1:0] l_cnt;

  exp_t sb_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load_valid(m_lv), .load_ready(m_ready),
    .load_data(m_data), .dout(m_dout), .dout_valid(m_dvalid),
    .frame_start(m_frame), .busy(m_busy), .word_cnt(m_cnt)
  );

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(2)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(l_lv), .load_ready(l_ready),
    .load_data(l_data), .dout(l_dout), .dout_valid(l_dvalid),
    .frame_start(l_frame), .busy(l_busy), .word_cnt(l_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w, input bit msb);
    exp_t x;
    for (int i = 0; i < 8; i++) begin
      x.b     = msb ? w[7-i] : w[i];
      x.first = (i == 0);
      sb_q.push_back(x);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    m_lv = 1'b0;
    l_lv = 1'b0;
    sb_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({m_dout, m_dvalid, m_frame, m_busy, m_ready} !== 5'b00001 || m_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: dout/valid/frame/busy/ready=%b cnt=%0d expected 00001 cnt=0",
               {m_dout, m_dvalid, m_frame, m_busy, m_ready}, m_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    pulse_reset();
    m_lv = 1'b1;
    m_data = 8'hB5;
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b expected 1", m_ready);
    end
    push_word(8'hB5, 1'b1);
    step();
    m_lv = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      e = sb_q.pop_front();
      checks++;
      if (m_dvalid !== 1'b1 || m_dout !== e.b || m_frame !== e.first) begin
        errors++;
        $display("[TB] FAIL single_bit%0d: valid/dout/frame=%b%b%b expected 1%b%b",
                 cyc, m_dvalid, m_dout, m_frame, e.b, e.first);
      end
      step();
    end
    checks++;
    if (m_dvalid !== 1'b0 || m_dout !== 1'b0 || m_busy !== 1'b0 || m_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL single_idle: valid=%b dout=%b busy=%b cnt=%0d expected 0 0 0 1",
               m_dvalid, m_dout, m_busy, m_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ready;
    pulse_reset();
    m_lv = 1'b1;
    m_data = 8'hB5;
    push_word(8'hB5, 1'b1);
    step();
    m_lv = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      exp_ready = !(cyc >= 4 && cyc <= 8);
      checks++;
      if (m_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL b2b_ready cyc%0d: got %b expected %b", cyc, m_ready, exp_ready);
      end
      e = sb_q.pop_front();
      checks++;
      if (m_dvalid !== 1'b1 || m_dout !== e.b || m_frame !== e.first) begin
        errors++;
        $display("[TB] FAIL b2b_bit%0d: valid/dout/frame=%b%b%b expected 1%b%b",
                 cyc, m_dvalid, m_dout, m_frame, e.b, e.first);
      end
      if (cyc == 3) begin
        m_lv = 1'b1;
        m_data = 8'h6C;
        push_word(8'h6C, 1'b1);
      end else begin
        m_lv = 1'b0;
      end
      step();
    end
    checks++;
    if (m_dvalid !== 1'b0 || m_busy !== 1'b0 || m_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL b2b_end: valid=%b busy=%b cnt=%0d expected 0 0 2", m_dvalid, m_busy, m_cnt);
    end
  endtask

  task automatic test_last_bit_bypass();
    pulse_reset();
    m_lv = 1'b1;
    m_data = 8'h00;
    push_word(8'h00, 1'b1);
    step();
    m_lv = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      e = sb_q.pop_front();
      checks++;
      if (m_dvalid !== 1'b1 || m_dout !== e.b || m_frame !== e.first) begin
        errors++;
        $display("[TB] FAIL bypass_bit%0d: valid/dout/frame=%b%b%b expected 1%b%b",
                 cyc, m_dvalid, m_dout, m_frame, e.b, e.first);
      end
      if (cyc == 8) begin
        checks++;
        if (m_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bypass_ready: got %b expected 1", m_ready);
        end
        m_lv = 1'b1;
        m_data = 8'hFF;
        push_word(8'hFF, 1'b1);
      end else begin
        m_lv = 1'b0;
      end
      step();
    end
    checks++;
    if (m_dvalid !== 1'b0 || m_dout !== 1'b0 || m_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL bypass_end: valid=%b dout=%b cnt=%0d expected 0 0 2", m_dvalid, m_dout, m_cnt);
    end
  endtask

  task automatic test_reset_mid_word();
    pulse_reset();
    m_lv = 1'b1;
    m_data = 8'hAA;
    push_word(8'hAA, 1'b1);
    step();
    m_lv = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      e = sb_q.pop_front();
      checks++;
      if (m_dvalid !== 1'b1 || m_dout !== e.b || m_frame !== e.first) begin
        errors++;
        $display("[TB] FAIL midrst_bit%0d: valid/dout/frame=%b%b%b expected 1%b%b",
                 cyc, m_dvalid, m_dout, m_frame, e.b, e.first);
      end
      if (cyc == 2) begin
        m_lv = 1'b1;
        m_data = 8'h55;
      end else begin
        m_lv = 1'b0;
      end
      if (cyc < 4) step();
    end
    checks++;
    if (m_busy !== 1'b1 || m_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_held: busy=%b ready=%b expected 1 0", m_busy, m_ready);
    end
    rst = 1'b1;
    m_lv = 1'b1;
    m_data = 8'hF0;
    #1;
    checks++;
    if ({m_dout, m_dvalid, m_frame, m_busy, m_ready} !== 5'b00001 || m_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midrst_async: dout/valid/frame/busy/ready=%b cnt=%0d expected 00001 cnt=0",
               {m_dout, m_dvalid, m_frame, m_busy, m_ready}, m_cnt);
    end
    step();
    step();
    rst = 1'b0;
    m_lv = 1'b0;
    sb_q.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      checks++;
      if (m_dvalid !== 1'b0 || m_dout !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_quiet cyc%0d: valid=%b dout=%b busy=%b expected 0 0 0",
                 cyc, m_dvalid, m_dout, m_busy);
      end
    end
  endtask

  task automatic test_lsb_first();
    pulse_reset();
    l_lv = 1'b1;
    l_data = 8'h01;
    push_word(8'h01, 1'b0);
    step();
    l_lv = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      e = sb_q.pop_front();
      checks++;
      if (l_dvalid !== 1'b1 || l_dout !== e.b || l_frame !== e.first) begin
        errors++;
        $display("[TB] FAIL lsb_bit%0d: valid/dout/frame=%b%b%b expected 1%b%b",
                 cyc, l_dvalid, l_dout, l_frame, e.b, e.first);
      end
      step();
    end
    checks++;
    if (l_dvalid !== 1'b0 || l_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL lsb_end: valid=%b cnt=%0d expected 0 1", l_dvalid, l_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    logic [7:0] w;
    logic [1:0] exp_cnt;
    pulse_reset();
    exp_cnt = 2'd0;
    for (int n = 0; n < 5; n++) begin
      w = 8'($urandom_range(0, 255));
      l_lv = 1'b1;
      l_data = w;
      push_word(w, 1'b0);
      step();
      l_lv = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
        e = sb_q.pop_front();
        checks++;
        if (l_dvalid !== 1'b1 || l_dout !== e.b || l_frame !== e.first) begin
          errors++;
          $display("[TB] FAIL wrap_w%0d_bit%0d: valid/dout/frame=%b%b%b expected 1%b%b",
                   n, cyc, l_dvalid, l_dout, l_frame, e.b, e.first);
        end
        step();
      end
      exp_cnt = exp_cnt + 2'd1;
      checks++;
      if (l_cnt !== exp_cnt) begin
        errors++;
        $display("[TB] FAIL wrap_cnt%0d: got %0d expected %0d", n, l_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    $display("[TB] starting piso_bit_feeder scenarios");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_last_bit_bypass();
    test_reset_mid_word();
    test_lsb_first();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_bit_feeder.md
Name: piso_bit_feeder

Overview:
- Parallel-in/serial-out feeder that drives the serial input `Din` of the team's Moore serial pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk, with no idle gap between back-to-back words.
- A one-word holding buffer behind the shift register allows gapless streaming.
- Outputs a fixed idle level whenever no word is in flight, so the downstream detector drains predictably.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first.
- IDLE_BIT, 0, level driven on dout when no word is in flight.
- CNT_W, 16, width of the wrapping sent-word counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  feeder can accept a word this cycle.
- load_data  in  WIDTH  word to serialise.
- dout  out  1  serial bit; connects to detector Din.
- dout_valid  out  1  dout carries a real data bit.
- frame_start  out  1  dout is the first bit of a word.
- busy  out  1  a word is shifting or held.
- word_cnt  out  CNT_W  completed words; wraps.

Behaviour:
- Reset is decided: rst is asynchronous, active-high; clock is clk.
- Reset values:
  - state = S_IDLE, hold_full = 0, bit_cnt = 0, word_cnt = 0.
  - dout = IDLE_BIT, dout_valid = 0, frame_start = 0, busy = 0, load_ready = 1.
- Handshake:
  - A transfer occurs on a rising edge with load_valid && load_ready.
  - load_ready = !hold_full (combinational).
  - The upstream must hold load_data stable while load_valid is high and load_ready is low.
- States:
  - S_IDLE: no word in flight.
  - S_SHIFT: shift register active, bit_cnt counts WIDTH-1 down to 0.
- S_IDLE + transfer:
  - The word loads directly into the shift register (bypassing hold); bit_cnt = WIDTH-1; go to S_SHIFT.
  - The first bit appears on dout at that edge (1-cycle latency from the accept edge), with dout_valid = 1 and frame_start = 1.
- S_SHIFT, bit_cnt > 0:
  - Shift one position per clk; bit_cnt decrements; frame_start = 0.
  - A transfer in this state writes the hold register and sets hold_full.
- S_SHIFT, bit_cnt == 0 (last bit on dout this cycle). At the edge, word_cnt increments and wraps mod 2^CNT_W; then:
  - hold_full: move hold into the shift register, clear hold_full, bit_cnt = WIDTH-1, frame_start = 1. No gap cycle.
  - else if a transfer occurs this cycle: bypass load, same as the hold case. No gap cycle.
  - else: go to S_IDLE; dout = IDLE_BIT, dout_valid = 0.
- Bit order:
  - MSB_FIRST = 1: dout = shift[WIDTH-1], shift left.
  - MSB_FIRST = 0: dout = shift[0], shift right.
- dout, dout_valid and frame_start are registered outputs. Bit order for the detector is therefore exact: no glitches, one bit per cycle.
- busy = (state == S_SHIFT) || hold_full.
- Hold-full boundary: a word never overwrites a full hold register, because load_ready is low.
- Reset mid-word: the partial word and the held word are discarded. Outputs return to their reset values immediately (asynchronous), and there is no resumption after reset is released.
- load_valid during reset is ignored.

Decomposition:
- Shared package/include holds:
  - state encodings S_IDLE = 1'b0, S_SHIFT = 1'b1;
  - default WIDTH and IDLE_BIT constants, reused by the detector-side testbench.
- No sub-module: shift register, hold buffer and counter form one block. Splitting the hold register out would add port overhead without reuse value.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: accept 8'hB5 in S_IDLE -> dout = 1,0,1,1,0,1,0,1 on the next 8 cycles; frame_start only on the first; then dout = 0, dout_valid = 0; word_cnt = 1.
- Back-to-back: accept 8'hB5, then 8'h6C on cycle 3 of shifting -> load_ready low from the accept until the handoff edge; 16 contiguous valid bits 10110101 01101100; frame_start at bits 1 and 9; word_cnt = 2.
- Last-bit bypass: with hold empty, present 8'hFF exactly on the last-bit cycle of 8'h00 -> accepted that edge; 8 zeros then 8 ones with no gap.
- LSB-first: MSB_FIRST=0, accept 8'h01 -> dout = 1,0,0,0,0,0,0,0.
- Reset mid-word: assert rst during bit 4 of 8'hAA with a word held -> dout = IDLE_BIT, dout_valid = 0, busy = 0, load_ready = 1, word_cnt = 0 immediately; nothing is emitted after release until a new load.
- Counter wrap, CNT_W=2: send 5 words -> word_cnt sequence 1,2,3,0,1.
